// File: rtl/instr_fetch_sequencer.sv
// Fetch controller for a byte-wide instruction memory: assembles four low
// nibbles into a 16-bit instruction and hands it to decode over valid/ready.
module instr_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] MemAddr,
    input  logic [7:0]  MemData,
    input  logic        Halt,
    input  logic        Redirect,
    input  logic [15:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [15:0] Instruction,
    output logic [15:0] InstrPC
);

    typedef enum logic [1:0] {
        NIB0 = 2'd0,
        NIB1 = 2'd1,
        NIB2 = 2'd2,
        NIB3 = 2'd3
    } idx_t;

    idx_t        idx, idx_nx;
    logic [15:0] fetch_pc, fetch_pc_nx;
    logic [3:0]  nib0, nib1, nib2;
    logic [3:0]  nib0_nx, nib1_nx, nib2_nx;
    logic        out_valid, out_valid_nx;
    logic [15:0] instr, instr_nx;
    logic [15:0] instr_pc, instr_pc_nx;
    logic        xfer;
    logic        unused_high;

    assign unused_high = ^MemData[7:4];

    assign MemAddr     = fetch_pc + {14'b0, idx};
    assign InstrValid  = out_valid;
    assign Instruction = instr;
    assign InstrPC     = instr_pc;

    // State register for fetch position, partial nibbles and output slot.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fetch_pc  <= RESET_PC;
            idx       <= NIB0;
            nib0      <= 4'h0;
            nib1      <= 4'h0;
            nib2      <= 4'h0;
            out_valid <= 1'b0;
            instr     <= 16'h0000;
            instr_pc  <= 16'h0000;
        end else begin
            fetch_pc  <= fetch_pc_nx;
            idx       <= idx_nx;
            nib0      <= nib0_nx;
            nib1      <= nib1_nx;
            nib2      <= nib2_nx;
            out_valid <= out_valid_nx;
            instr     <= instr_nx;
            instr_pc  <= instr_pc_nx;
        end
    end

    // Next-state: redirect beats everything, then handshake, then fetch step.
    always_comb begin
        xfer         = out_valid & InstrReady;
        fetch_pc_nx  = fetch_pc;
        idx_nx       = idx;
        nib0_nx      = nib0;
        nib1_nx      = nib1;
        nib2_nx      = nib2;
        out_valid_nx = out_valid;
        instr_nx     = instr;
        instr_pc_nx  = instr_pc;

        if (Redirect) begin
            fetch_pc_nx  = RedirectPC;
            idx_nx       = NIB0;
            out_valid_nx = 1'b0;
        end else begin
            if (xfer) begin
                out_valid_nx = 1'b0;
            end else begin
                out_valid_nx = out_valid;
            end

            if (Halt) begin
                idx_nx = idx;
            end else begin
                case (idx)
                    NIB0: begin
                        nib0_nx = MemData[3:0];
                        idx_nx  = NIB1;
                    end
                    NIB1: begin
                        nib1_nx = MemData[3:0];
                        idx_nx  = NIB2;
                    end
                    NIB2: begin
                        nib2_nx = MemData[3:0];
                        idx_nx  = NIB3;
                    end
                    NIB3: begin
                        // Slot is free if it was empty or is being drained now.
                        if (!out_valid_nx) begin
                            instr_nx     = {nib0, nib1, nib2, MemData[3:0]};
                            instr_pc_nx  = fetch_pc;
                            out_valid_nx = 1'b1;
                            fetch_pc_nx  = fetch_pc + 16'd4;
                            idx_nx       = NIB0;
                        end else begin
                            idx_nx = NIB3;
                        end
                    end
                    default: begin
                        idx_nx = NIB0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench: directed vector table, reset corner case, and random
// traffic against a queue-based reference model of the fetch rules.
module tb_instr_fetch_sequencer;

    logic        Clock;
    logic        Reset;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic        Halt;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] Instruction;
    logic [15:0] InstrPC;

    logic [7:0] mem [0:65535];

    int n_cmp;
    int n_bad;

    instr_fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .MemAddr     (MemAddr),
        .MemData     (MemData),
        .Halt        (Halt),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instruction (Instruction),
        .InstrPC     (InstrPC)
    );

    assign MemData = mem[MemAddr];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch PC plus a queue of collected nibbles.
    logic [15:0] m_pc;
    logic [3:0]  nibq[$];
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic        mchk;

    task automatic model_reset();
        m_pc    = 16'h0000;
        nibq.delete();
        m_valid = 1'b0;
        m_instr = 16'h0000;
        m_ipc   = 16'h0000;
    endtask

    always @(posedge Clock or posedge Reset) begin
        logic [15:0] a;
        if (Reset) begin
            model_reset();
        end else if (Redirect) begin
            m_pc = RedirectPC;
            nibq.delete();
            m_valid = 1'b0;
        end else begin
            if (m_valid && InstrReady) m_valid = 1'b0;
            if (!Halt) begin
                a = m_pc + 16'(nibq.size());
                if (nibq.size() < 3) begin
                    nibq.push_back(mem[a][3:0]);
                end else if (!m_valid) begin
                    m_instr = {nibq[0], nibq[1], nibq[2], mem[a][3:0]};
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 16'd4;
                    nibq.delete();
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (mchk) begin
            check("model_valid", {15'b0, InstrValid}, {15'b0, m_valid});
            check("model_addr", MemAddr, m_pc + 16'(nibq.size()));
            if (m_valid) begin
                check("model_instr", Instruction, m_instr);
                check("model_pc", InstrPC, m_ipc);
            end
        end
    end

    typedef struct {
        logic        halt;
        logic        redir;
        logic [15:0] rpc;
        logic        rdy;
        logic        ev;
        logic [15:0] ei;
        logic [15:0] ep;
        logic [15:0] ea;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic h, logic r, logic [15:0] rp, logic rd,
                                logic ev, logic [15:0] ei, logic [15:0] ep, logic [15:0] ea);
        vec_t v;
        v.halt = h; v.redir = r; v.rpc = rp; v.rdy = rd;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea;
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mchk  = 1'b0;
        model_reset();
        Reset = 1'b1;
        Halt = 1'b0;
        Redirect = 1'b0;
        RedirectPC = 16'h0000;
        InstrReady = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        mem[4] = 8'h05; mem[5] = 8'h06; mem[6] = 8'h07; mem[7] = 8'h08;
        mem[16'h0040] = 8'hA5; mem[16'h0041] = 8'hFB;
        mem[16'h0042] = 8'h3C; mem[16'h0043] = 8'h7D;
        mem[16'hFFFE] = 8'h9E; mem[16'hFFFF] = 8'h8F;

        // Startup, back-pressure, redirect, wrap and halt, edge by edge.
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0001));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0002));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0003));
        vt.push_back(mk(0, 0, 16'h0, 1, 1, 16'h1234, 16'h0, 16'h0004));
        vt.push_back(mk(0, 0, 16'h0, 0, 1, 16'h1234, 16'h0, 16'h0005));
        vt.push_back(mk(0, 0, 16'h0, 0, 1, 16'h1234, 16'h0, 16'h0006));
        vt.push_back(mk(0, 0, 16'h0, 0, 1, 16'h1234, 16'h0, 16'h0007));
        for (int i = 0; i < 7; i++)
            vt.push_back(mk(0, 0, 16'h0, 0, 1, 16'h1234, 16'h0, 16'h0007));
        vt.push_back(mk(0, 0, 16'h0, 1, 1, 16'h5678, 16'h0004, 16'h0008));
        vt.push_back(mk(0, 0, 16'h0, 0, 1, 16'h5678, 16'h0004, 16'h0009));
        vt.push_back(mk(0, 0, 16'h0, 0, 1, 16'h5678, 16'h0004, 16'h000A));
        vt.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0, 16'h0, 16'h0040));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0041));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0042));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0043));
        vt.push_back(mk(0, 0, 16'h0, 1, 1, 16'h5BCD, 16'h0040, 16'h0044));
        vt.push_back(mk(0, 1, 16'hFFFE, 1, 0, 16'h0, 16'h0, 16'hFFFE));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'hFFFF));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0000));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0001));
        vt.push_back(mk(0, 0, 16'h0, 1, 1, 16'hEF12, 16'hFFFE, 16'h0002));
        vt.push_back(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0003));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(1, 0, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0003));

        repeat (2) @(negedge Clock);
        check("reset_valid", {15'b0, InstrValid}, 16'h0000);
        check("reset_addr", MemAddr, 16'h0000);
        check("reset_instr", Instruction, 16'h0000);
        check("reset_pc", InstrPC, 16'h0000);
        Reset = 1'b0;
        mchk  = 1'b1;

        foreach (vt[k]) begin
            Halt       = vt[k].halt;
            Redirect   = vt[k].redir;
            RedirectPC = vt[k].rpc;
            InstrReady = vt[k].rdy;
            @(posedge Clock);
            @(negedge Clock);
            check($sformatf("vec%0d_valid", k), {15'b0, InstrValid}, {15'b0, vt[k].ev});
            check($sformatf("vec%0d_addr", k), MemAddr, vt[k].ea);
            if (vt[k].ev) begin
                check($sformatf("vec%0d_instr", k), Instruction, vt[k].ei);
                check($sformatf("vec%0d_pc", k), InstrPC, vt[k].ep);
            end
        end

        // Reset asserted mid-cycle while halted mid-fetch acts immediately.
        Halt = 1'b1;
        Redirect = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("async_valid", {15'b0, InstrValid}, 16'h0000);
        check("async_addr", MemAddr, 16'h0000);
        check("async_instr", Instruction, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;
        Halt = 1'b0;
        InstrReady = 1'b1;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("restart_valid", {15'b0, InstrValid}, 16'h0001);
        check("restart_instr", Instruction, 16'h1234);
        check("restart_pc", InstrPC, 16'h0000);

        // Random traffic checked by the reference model every cycle.
        for (int c = 0; c < 4000; c++) begin
            Halt       = ($urandom_range(7) == 0);
            Redirect   = ($urandom_range(15) == 0);
            RedirectPC = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3))
                                                  : 16'($urandom);
            InstrReady = ($urandom_range(1) == 1);
            if ($urandom_range(499) == 0) begin
                #2;
                Reset = 1'b1;
                #1;
                check("rand_reset_valid", {15'b0, InstrValid}, 16'h0000);
                check("rand_reset_addr", MemAddr, 16'h0000);
                @(negedge Clock);
                Reset = 1'b0;
            end else begin
                @(negedge Clock);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
